// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C controller arbiter.
// Holds the FSM state encoding, the returned error codes and the watchdog sizing helper.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // The watchdog only has to reach TIMEOUT_CYCLES-1, so $clog2 bits are enough.
    function automatic int wdog_width(input int timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker.
// Grants the first pending request found scanning upward from last+1, wrapping at N_REQ.
module i2c_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         pick,
    output logic                     valid
);

    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == (int'(last) + i) % N_REQ)) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of one shared I2C_Controller.
// Grants one requester, launches its transaction, waits for completion under a watchdog, returns done/err.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_rw,
    input  logic [N_REQ*8-1:0]        req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic [1:0]                err_code,
    output logic                      ctl_init,
    output logic                      ctl_rw,
    output logic [7:0]                ctl_address,
    output logic [DATA_W-1:0]         ctl_data,
    output logic                      ctl_abort,
    input  logic                      ctl_done,
    input  logic                      ctl_nack
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state, state_next;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic [N_REQ-1:0]   pick;
    logic               pick_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               win_rw;
    logic [7:0]         win_addr;
    logic [DATA_W-1:0]  win_data;

    logic [N_REQ-1:0]   grant_d, done_d, err_d;
    logic [1:0]         err_code_d;
    logic               init_d, abort_d, rw_d;
    logic [7:0]         addr_d;
    logic [DATA_W-1:0]  data_d;

    i2c_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req_valid),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // The pick is one-hot, so at most one slice of the request fields is selected.
    always_comb begin
        win_idx  = '0;
        win_rw   = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                win_idx  = IDX_W'(i);
                win_rw   = req_rw[i];
                win_addr = req_addr[i*8 +: 8];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        last_d     = last_q;
        wdog_d     = wdog_q;
        grant_d    = req_grant;
        done_d     = '0;
        err_d      = '0;
        err_code_d = ERR_OK;
        init_d     = 1'b0;
        abort_d    = 1'b0;
        rw_d       = ctl_rw;
        addr_d     = ctl_address;
        data_d     = ctl_data;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_WAIT;
                    last_d     = win_idx;
                    wdog_d     = '0;
                    grant_d    = pick;
                    init_d     = 1'b1;
                    rw_d       = win_rw;
                    addr_d     = win_addr;
                    data_d     = win_data;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (ctl_done) begin
                    state_next = ST_RELEASE;
                    grant_d    = '0;
                    done_d     = req_grant;
                    err_d      = ctl_nack ? req_grant : '0;
                    err_code_d = ctl_nack ? ERR_NACK : ERR_OK;
                end else if (wdog_q == WD_LAST) begin
                    state_next = ST_RELEASE;
                    grant_d    = '0;
                    done_d     = req_grant;
                    err_d      = req_grant;
                    err_code_d = ERR_TIMEOUT;
                    abort_d    = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                grant_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_q      <= IDX_W'(N_REQ - 1);
            wdog_q      <= '0;
            req_grant   <= '0;
            req_done    <= '0;
            req_err     <= '0;
            err_code    <= ERR_OK;
            ctl_init    <= 1'b0;
            ctl_abort   <= 1'b0;
            ctl_rw      <= 1'b0;
            ctl_address <= '0;
            ctl_data    <= '0;
        end else begin
            state       <= state_next;
            last_q      <= last_d;
            wdog_q      <= wdog_d;
            req_grant   <= grant_d;
            req_done    <= done_d;
            req_err     <= err_d;
            err_code    <= err_code_d;
            ctl_init    <= init_d;
            ctl_abort   <= abort_d;
            ctl_rw      <= rw_d;
            ctl_address <= addr_d;
            ctl_data    <= data_d;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized traffic against a round-robin model.
// A second instance with a 16-cycle watchdog covers the timeout boundary.
module tb_i2c_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int T_MAIN = 64;
    localparam int T_TO   = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid, req_rw;
    logic [N*8-1:0]    req_addr;
    logic [N*DW-1:0]   req_data;
    logic              ctl_done, ctl_nack;

    logic [N-1:0]      req_grant, req_done, req_err;
    logic [1:0]        err_code;
    logic              ctl_init, ctl_rw, ctl_abort;
    logic [7:0]        ctl_address;
    logic [DW-1:0]     ctl_data;

    logic [N-1:0]      to_req_grant, to_req_done, to_req_err;
    logic [1:0]        to_err_code;
    logic              to_ctl_init, to_ctl_rw, to_ctl_abort;
    logic [7:0]        to_ctl_address;
    logic [DW-1:0]     to_ctl_data;

    int total = 0;
    int bad   = 0;
    int model_last;

    i2c_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(T_MAIN)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .err_code(err_code),
        .ctl_init(ctl_init), .ctl_rw(ctl_rw), .ctl_address(ctl_address), .ctl_data(ctl_data),
        .ctl_abort(ctl_abort), .ctl_done(ctl_done), .ctl_nack(ctl_nack)
    );

    i2c_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(T_TO)) u_dut_to (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .req_grant(to_req_grant), .req_done(to_req_done), .req_err(to_req_err), .err_code(to_err_code),
        .ctl_init(to_ctl_init), .ctl_rw(to_ctl_rw), .ctl_address(to_ctl_address), .ctl_data(to_ctl_data),
        .ctl_abort(to_ctl_abort), .ctl_done(ctl_done), .ctl_nack(ctl_nack)
    );

    always #5 clock = ~clock;

    // Round-robin rule: first pending requester scanning upward from last+1, wrapping.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int i = 1; i <= N; i++) begin
            if (((mask >> ((last + i) % N)) & 1) != 0) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_data  = '0;
        ctl_done  = 1'b0;
        ctl_nack  = 1'b0;
        repeat (2) step();
        reset_n    = 1'b1;
        step();
        model_last = N - 1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_data  = '0;
        ctl_done  = 1'b0;
        ctl_nack  = 1'b0;
        #2;
        total++;
        if ({req_grant, req_done, req_err, err_code, ctl_init, ctl_abort, ctl_rw, ctl_address, ctl_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {req_grant, req_done, req_err, err_code, ctl_init, ctl_abort, ctl_rw, ctl_address, ctl_data});
        end
        total++;
        if ({to_req_grant, to_req_done, to_req_err, to_err_code, to_ctl_init, to_ctl_abort, to_ctl_rw, to_ctl_address, to_ctl_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_to got=%h exp=0", {to_req_grant, to_req_done, to_req_err, to_err_code, to_ctl_init, to_ctl_abort, to_ctl_rw, to_ctl_address, to_ctl_data});
        end
        step();
        reset_n = 1'b1;
        repeat (3) step();
        total++;
        if ({req_grant, ctl_init} !== '0) begin
            bad++;
            $display("[TB] FAIL idle_no_request got=%b exp=0", {req_grant, ctl_init});
        end
        model_last = N - 1;
    endtask

    task automatic test_single();
        int early;
        do_reset();
        req_valid = 4'b0001;
        req_rw    = 4'b1110;
        req_addr  = 32'hA5C3_771F;
        req_data  = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'd32};
        step();
        total++;
        if ({ctl_init, req_grant} !== 5'b1_0001) begin
            bad++;
            $display("[TB] FAIL single_grant got=%b exp=%b", {ctl_init, req_grant}, 5'b1_0001);
        end
        total++;
        if ({ctl_rw, ctl_address, ctl_data} !== {1'b0, 8'h1F, 32'd32}) begin
            bad++;
            $display("[TB] FAIL single_fields got=%h exp=%h", {ctl_rw, ctl_address, ctl_data}, {1'b0, 8'h1F, 32'd32});
        end
        req_addr = 32'h0102_0304;
        req_data = '1;
        early = 0;
        for (int j = 0; j < 50; j++) begin
            step();
            if (req_done !== '0 || ctl_init !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("[TB] FAIL single_wait_quiet got=%0d exp=0", early);
        end
        ctl_done = 1'b1;
        ctl_nack = 1'b0;
        step();
        ctl_done  = 1'b0;
        req_valid = '0;
        total++;
        if ({req_done, req_err, err_code, req_grant} !== {4'b0001, 4'b0000, 2'b00, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL single_done got=%b exp=%b", {req_done, req_err, err_code, req_grant}, {4'b0001, 4'b0000, 2'b00, 4'b0000});
        end
        total++;
        if ({ctl_address, ctl_data} !== {8'h1F, 32'd32}) begin
            bad++;
            $display("[TB] FAIL single_fields_stable got=%h exp=%h", {ctl_address, ctl_data}, {8'h1F, 32'd32});
        end
        step();
        total++;
        if (req_done !== '0) begin
            bad++;
            $display("[TB] FAIL single_done_pulse got=%b exp=0000", req_done);
        end
    endtask

    task automatic test_fairness();
        int waited;
        int exp;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = rr_pick(req_valid, model_last);
            waited = 0;
            while (req_grant === '0 && waited < 6) begin
                step();
                waited++;
            end
            total++;
            if (waited != ((k == 0) ? 1 : 2)) begin
                bad++;
                $display("[TB] FAIL fair_gap txn=%0d got=%0d exp=%0d", k, waited, (k == 0) ? 1 : 2);
            end
            total++;
            if (req_grant !== 4'(1 << exp)) begin
                bad++;
                $display("[TB] FAIL fair_order txn=%0d got=%b exp=%b", k, req_grant, 4'(1 << exp));
            end
            model_last = exp;
            repeat ($urandom_range(0, 5)) step();
            ctl_done = 1'b1;
            ctl_nack = 1'b0;
            step();
            ctl_done = 1'b0;
            total++;
            if (req_done !== 4'(1 << exp)) begin
                bad++;
                $display("[TB] FAIL fair_done txn=%0d got=%b exp=%b", k, req_done, 4'(1 << exp));
            end
        end
        req_valid = '0;
        repeat (2) step();
    endtask

    task automatic test_nack();
        do_reset();
        req_valid = 4'b0100;
        step();
        total++;
        if (req_grant !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL nack_grant got=%b exp=0100", req_grant);
        end
        repeat (3) step();
        ctl_done = 1'b1;
        ctl_nack = 1'b1;
        step();
        ctl_done  = 1'b0;
        ctl_nack  = 1'b0;
        req_valid = '0;
        total++;
        if ({req_done, req_err, err_code, ctl_abort} !== {4'b0100, 4'b0100, 2'b01, 1'b0}) begin
            bad++;
            $display("[TB] FAIL nack_result got=%b exp=%b", {req_done, req_err, err_code, ctl_abort}, {4'b0100, 4'b0100, 2'b01, 1'b0});
        end
        step();
        total++;
        if ({req_err, err_code} !== '0) begin
            bad++;
            $display("[TB] FAIL nack_clear got=%b exp=0", {req_err, err_code});
        end
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        req_valid = 4'b0001;
        step();
        total++;
        if (to_ctl_init !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_init got=%b exp=1", to_ctl_init);
        end
        cyc = 0;
        while (to_ctl_abort !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        total++;
        if (cyc != T_TO) begin
            bad++;
            $display("[TB] FAIL to_abort_delay got=%0d exp=%0d", cyc, T_TO);
        end
        total++;
        if ({to_req_done, to_req_err, to_err_code} !== {4'b0001, 4'b0001, 2'b10}) begin
            bad++;
            $display("[TB] FAIL to_result got=%b exp=%b", {to_req_done, to_req_err, to_err_code}, {4'b0001, 4'b0001, 2'b10});
        end
        req_valid = '0;
        step();
        total++;
        if ({to_ctl_abort, to_req_done} !== '0) begin
            bad++;
            $display("[TB] FAIL to_abort_pulse got=%b exp=0", {to_ctl_abort, to_req_done});
        end
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0001;
        repeat (T_TO - 1) step();
        ctl_done = 1'b1;
        ctl_nack = 1'b0;
        step();
        ctl_done  = 1'b0;
        req_valid = '0;
        total++;
        if ({to_req_done, to_req_err, to_err_code, to_ctl_abort} !== {4'b0001, 4'b0000, 2'b00, 1'b0}) begin
            bad++;
            $display("[TB] FAIL to_last_cycle_done got=%b exp=%b", {to_req_done, to_req_err, to_err_code, to_ctl_abort}, {4'b0001, 4'b0000, 2'b00, 1'b0});
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req_valid = 4'b0010;
        req_rw    = 4'b0010;
        req_addr  = 32'h0000_5A00;
        req_data  = {32'h0, 32'h0, 32'h7777_0001, 32'h0};
        step();
        total++;
        if ({req_grant, ctl_rw, ctl_address} !== {4'b0010, 1'b1, 8'h5A}) begin
            bad++;
            $display("[TB] FAIL rst_wait_grant got=%h exp=%h", {req_grant, ctl_rw, ctl_address}, {4'b0010, 1'b1, 8'h5A});
        end
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_grant, req_done, req_err, err_code, ctl_init, ctl_abort, ctl_rw, ctl_address, ctl_data} !== '0) begin
            bad++;
            $display("[TB] FAIL rst_wait_async got=%h exp=0", {req_grant, req_done, req_err, err_code, ctl_init, ctl_abort, ctl_rw, ctl_address, ctl_data});
        end
        step();
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        step();
        total++;
        if ({req_grant, req_done} !== {4'b0001, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL rst_wait_first got=%b exp=%b", {req_grant, req_done}, {4'b0001, 4'b0000});
        end
        req_valid = '0;
    endtask

    task automatic test_drop();
        int regrants;
        do_reset();
        req_valid = 4'b1000;
        step();
        total++;
        if (req_grant !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL drop_grant got=%b exp=1000", req_grant);
        end
        step();
        req_valid = '0;
        repeat (4) step();
        ctl_done = 1'b1;
        step();
        ctl_done = 1'b0;
        total++;
        if (req_done !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL drop_done got=%b exp=1000", req_done);
        end
        regrants = 0;
        for (int j = 0; j < 5; j++) begin
            step();
            if (req_grant !== '0 || ctl_init !== 1'b0) regrants++;
        end
        total++;
        if (regrants != 0) begin
            bad++;
            $display("[TB] FAIL drop_no_regrant got=%0d exp=0", regrants);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]  mask;
        logic          exp_rw, nack, cap_abort;
        logic [7:0]    exp_addr;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  cap_done, cap_err, cap_grant, exp_oh;
        logic [1:0]    cap_code, exp_code;
        int            exp, d, got, exp_rel;
        do_reset();
        mask = '0;
        for (int t = 0; t < 40; t++) begin
            mask = mask | 4'($urandom_range(0, 15));
            if (mask == '0) mask = 4'($urandom_range(1, 15));
            req_valid = mask;
            req_rw    = 4'($urandom);
            req_addr  = $urandom;
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            ctl_done  = ($urandom_range(0, 3) == 0);
            exp       = rr_pick(mask, model_last);
            exp_oh    = 4'(1 << exp);
            exp_rw    = 1'(req_rw >> exp);
            exp_addr  = 8'(req_addr >> (8 * exp));
            exp_data  = DW'(req_data >> (DW * exp));
            step();
            ctl_done = 1'b0;
            total++;
            if ({ctl_init, req_grant, ctl_rw, ctl_address, ctl_data} !== {1'b1, exp_oh, exp_rw, exp_addr, exp_data}) begin
                bad++;
                $display("[TB] FAIL rand_grant txn=%0d got=%h exp=%h", t, {ctl_init, req_grant, ctl_rw, ctl_address, ctl_data}, {1'b1, exp_oh, exp_rw, exp_addr, exp_data});
            end
            model_last = exp;
            req_addr = $urandom;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) mask[exp] = 1'b0;
            mask      = mask | 4'($urandom_range(0, 15) & ~exp_oh);
            req_valid = mask;
            d    = $urandom_range(0, T_MAIN + 8);
            nack = 1'($urandom);
            got  = -1;
            cap_done = '0; cap_err = '0; cap_grant = '0; cap_code = '0; cap_abort = 1'b0;
            for (int j = 0; j < T_MAIN + 4 && got < 0; j++) begin
                ctl_done = (j == d);
                ctl_nack = (j == d) ? nack : 1'($urandom);
                step();
                if (req_done !== '0) begin
                    got       = j + 1;
                    cap_done  = req_done;
                    cap_err   = req_err;
                    cap_code  = err_code;
                    cap_abort = ctl_abort;
                    cap_grant = req_grant;
                end
            end
            ctl_done = 1'b0;
            exp_rel  = (d < T_MAIN) ? d + 1 : T_MAIN;
            exp_code = (d < T_MAIN) ? {1'b0, nack} : 2'b10;
            total++;
            if (got != exp_rel) begin
                bad++;
                $display("[TB] FAIL rand_latency txn=%0d got=%0d exp=%0d", t, got, exp_rel);
            end
            total++;
            if ({cap_done, cap_err, cap_code, cap_abort, cap_grant} !==
                {exp_oh, (exp_code != 2'b00) ? exp_oh : 4'b0000, exp_code, d >= T_MAIN, 4'b0000}) begin
                bad++;
                $display("[TB] FAIL rand_result txn=%0d got=%b exp=%b", t, {cap_done, cap_err, cap_code, cap_abort, cap_grant},
                         {exp_oh, (exp_code != 2'b00) ? exp_oh : 4'b0000, exp_code, d >= T_MAIN, 4'b0000});
            end
            total++;
            if ({ctl_address, ctl_data} !== {exp_addr, exp_data}) begin
                bad++;
                $display("[TB] FAIL rand_stable txn=%0d got=%h exp=%h", t, {ctl_address, ctl_data}, {exp_addr, exp_data});
            end
            mask[exp] = 1'b0;
            req_valid = mask;
            step();
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        $display("[TB] starting i2c_arbiter bench");
        test_reset();
        test_single();
        test_fairness();
        test_nack();
        test_timeout();
        test_reset_mid_wait();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
